// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit: operand width, divide op
// encodings, divider FSM states and the W-result sign-extension helper.
package mdu_pkg;

    localparam int XLEN = 64;

    typedef enum logic [1:0] {
        DIV_OP_DIV  = 2'd0,
        DIV_OP_DIVU = 2'd1,
        DIV_OP_REM  = 2'd2,
        DIV_OP_REMU = 2'd3
    } div_op_e;

    typedef enum logic [2:0] {
        DIV_IDLE,
        DIV_CALC,
        DIV_FIX,
        DIV_SPECIAL,
        DIV_DONE
    } div_state_e;

    function automatic logic [XLEN-1:0] sext_w(input logic [XLEN-1:0] x);
        return {{(XLEN-32){x[31]}}, x[31:0]};
    endfunction

endpackage

// File: rtl/div_iter_step.sv
// One radix-2 restoring divide iteration: shift {rem,quo} left by one,
// trial-subtract the divisor and shift in the quotient bit.
module div_iter_step #(
    parameter int W = 64
) (
    input  logic [W-1:0] rem_i,
    input  logic [W-1:0] quo_i,
    input  logic [W-1:0] div_i,
    output logic [W-1:0] rem_o,
    output logic [W-1:0] quo_o
);

    logic [W:0] shifted;
    logic [W:0] trial;
    logic       no_borrow;

    // rem < div always holds, so the shifted value fits in W+1 bits and the
    // top bit of the difference is a clean borrow flag.
    assign shifted   = {rem_i, quo_i[W-1]};
    assign trial     = shifted - {1'b0, div_i};
    assign no_borrow = ~trial[W];

    assign rem_o = no_borrow ? trial[W-1:0] : shifted[W-1:0];
    assign quo_o = {quo_i[W-2:0], no_borrow};

endmodule

// File: rtl/mdu_div_seq.sv
// Iterative RV64M divider (DIV/DIVU/REM/REMU and W forms), one quotient bit
// per cycle, valid/ready on both sides with pipeline flush.
module mdu_div_seq #(
    parameter int XLEN = 64
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      in_op,
    input  logic            in_is_w,
    input  logic [XLEN-1:0] in_src1,
    input  logic [XLEN-1:0] in_src2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result
);
    import mdu_pkg::*;

    div_state_e      state_q, state_d;
    logic [6:0]      cnt_q, cnt_d;
    logic [XLEN-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d, res_q, res_d;
    div_op_e         op_q, op_d;
    logic            is_w_q, is_w_d, neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;

    // Request-side operand preparation
    div_op_e         op_in;
    logic            signed_op, is_rem_in, sa, sb, div0, ovf;
    logic [XLEN-1:0] a, b, abs_a, abs_b, most_neg, spec_res;

    assign op_in     = div_op_e'(in_op);
    assign signed_op = (op_in == DIV_OP_DIV) || (op_in == DIV_OP_REM);
    assign is_rem_in = in_op[1];
    assign a = !in_is_w ? in_src1 :
               signed_op ? sext_w(in_src1) : {{(XLEN-32){1'b0}}, in_src1[31:0]};
    assign b = !in_is_w ? in_src2 :
               signed_op ? sext_w(in_src2) : {{(XLEN-32){1'b0}}, in_src2[31:0]};
    assign sa       = signed_op & a[XLEN-1];
    assign sb       = signed_op & b[XLEN-1];
    assign abs_a    = sa ? -a : a;
    assign abs_b    = sb ? -b : b;
    assign most_neg = in_is_w ? {{(XLEN-31){1'b1}}, 31'b0} : {1'b1, {(XLEN-1){1'b0}}};
    assign div0     = (b == '0);
    assign ovf      = signed_op && (a == most_neg) && (b == '1);

    always_comb begin
        spec_res = '0;
        if (div0)
            spec_res = is_rem_in ? a : '1;
        else if (ovf)
            spec_res = is_rem_in ? '0 : a;
        if (in_is_w)
            spec_res = sext_w(spec_res);
    end

    logic [XLEN-1:0] step_rem, step_quo;

    div_iter_step #(.W(XLEN)) u_step (
        .rem_i (rem_q),
        .quo_i (quo_q),
        .div_i (dvs_q),
        .rem_o (step_rem),
        .quo_o (step_quo)
    );

    logic [XLEN-1:0] fix_q, fix_r, fix_res;
    assign fix_q   = neg_quo_q ? -quo_q : quo_q;
    assign fix_r   = neg_rem_q ? -rem_q : rem_q;
    assign fix_res = op_q[1] ? fix_r : fix_q;

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvs_d     = dvs_q;
        res_d     = res_q;
        op_d      = op_q;
        is_w_d    = is_w_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        unique case (state_q)
            DIV_IDLE: if (in_valid) begin
                op_d      = op_in;
                is_w_d    = in_is_w;
                neg_quo_d = sa ^ sb;
                neg_rem_d = sa;
                dvs_d     = abs_b;
                cnt_d     = '0;
                // Special results park in rem_q until SPECIAL registers them
                if (div0 || ovf) begin
                    rem_d   = spec_res;
                    state_d = DIV_SPECIAL;
                end else begin
                    rem_d   = '0;
                    quo_d   = in_is_w ? {abs_a[31:0], 32'b0} : abs_a;
                    state_d = DIV_CALC;
                end
            end
            DIV_CALC: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q + 7'd1;
                if (cnt_q == (is_w_q ? 7'd31 : 7'd63)) begin
                    cnt_d   = '0;
                    state_d = DIV_FIX;
                end
            end
            DIV_FIX: begin
                res_d   = is_w_q ? sext_w(fix_res) : fix_res;
                state_d = DIV_DONE;
            end
            DIV_SPECIAL: begin
                res_d   = rem_q;
                state_d = DIV_DONE;
            end
            DIV_DONE: if (out_ready) state_d = DIV_IDLE;
            default: state_d = DIV_IDLE;
        endcase
        if (flush) begin
            state_d = DIV_IDLE;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q   <= DIV_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dvs_q     <= '0;
            res_q     <= '0;
            op_q      <= DIV_OP_DIV;
            is_w_q    <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dvs_q     <= dvs_d;
            res_q     <= res_d;
            op_q      <= op_d;
            is_w_q    <= is_w_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
        end
    end

    assign in_ready   = (state_q == DIV_IDLE);
    assign out_valid  = (state_q == DIV_DONE);
    assign out_result = res_q;

endmodule

// File: tb/tb_mdu_div_seq.sv
// Directed bench for mdu_div_seq: hand-computed results, latencies, special
// cases, flush, reset and output backpressure.
module tb_mdu_div_seq;

    logic        clock = 1'b0;
    logic        reset, flush, in_valid, in_is_w, out_ready;
    logic [1:0]  in_op;
    logic [63:0] in_src1, in_src2;
    logic        in_ready, out_valid;
    logic [63:0] out_result;

    int checks = 0;
    int errors = 0;

    localparam logic [1:0] OP_DIV = 2'd0, OP_DIVU = 2'd1, OP_REM = 2'd2, OP_REMU = 2'd3;

    mdu_div_seq #(.XLEN(64)) dut (
        .clock      (clock),
        .reset      (reset),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_is_w    (in_is_w),
        .in_src1    (in_src1),
        .in_src2    (in_src2),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h exp %h", tag, act, exp);
        end
    endtask

    // Issue one request from IDLE and wait for out_valid; lat counts the
    // accept edge as cycle 1.
    task automatic do_op(input logic [1:0] op, input logic w, input logic [63:0] a,
                         input logic [63:0] b, output logic [63:0] res, output int lat);
        in_op = op; in_is_w = w; in_src1 = a; in_src2 = b; in_valid = 1'b1;
        @(posedge clock); #1;
        in_valid = 1'b0;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clock); #1;
            lat++;
        end
        if (!out_valid) chk("timeout", {63'b0, out_valid}, 64'd1);
        res = out_result;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [1:0] op, input logic w,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] exp, input int exp_lat);
        logic [63:0] r;
        int          l;
        do_op(op, w, a, b, r, l);
        chk(tag, r, exp);
        chk({tag, "_lat"}, 64'(l), 64'(exp_lat));
        consume();
    endtask

    initial begin
        logic [63:0] r;
        int          l, vcnt;
        reset = 1'b1; flush = 1'b0; in_valid = 1'b0; in_is_w = 1'b0; out_ready = 1'b0;
        in_op = OP_DIV; in_src1 = '0; in_src2 = '0;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
        chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("rst_result",    out_result,         64'd0);

        run("div_neg",   OP_DIV,  1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
        run("rem_neg",   OP_REM,  1'b0, -64'sd20, 64'd3, 64'hFFFF_FFFF_FFFF_FFFE, 66);
        run("rem_pos",   OP_REM,  1'b0, 64'd20,  -64'sd3, 64'd2, 66);
        run("div_pneg",  OP_DIV,  1'b0, 64'd20,  -64'sd3, 64'hFFFF_FFFF_FFFF_FFFA, 66);
        run("divu_max",  OP_DIVU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'h0FFF_FFFF_FFFF_FFFF, 66);
        run("remu_max",  OP_REMU, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h10, 64'hF, 66);
        run("div_zero",  OP_DIV,  1'b0, 64'd7, 64'd0, 64'hFFFF_FFFF_FFFF_FFFF, 2);
        run("rem_zero",  OP_REM,  1'b0, 64'd7, 64'd0, 64'd7, 2);
        run("div_ovf",   OP_DIV,  1'b0, 64'h8000_0000_0000_0000, '1, 64'h8000_0000_0000_0000, 2);
        run("remw_ovf",  OP_REM,  1'b1, 64'h8000_0000, '1, 64'd0, 2);
        run("divuw_sx",  OP_DIVU, 1'b1, 64'hFFFF_FFFF_8000_0000, 64'd1, 64'hFFFF_FFFF_8000_0000, 34);
        run("divw_neg",  OP_DIV,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFD, 34);
        run("remw_neg",  OP_REM,  1'b1, 64'h1234_5678_FFFF_FFF9, 64'd2, 64'hFFFF_FFFF_FFFF_FFFF, 34);
        run("remuw",     OP_REMU, 1'b1, 64'hABCD_0000_0000_0064, 64'd7, 64'd2, 34);
        run("divuw_z",   OP_DIVU, 1'b1, 64'd5, 64'hFFFF_FFFF_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 2);

        // Flush during CALC iteration 10
        in_op = OP_DIV; in_is_w = 1'b0; in_src1 = 64'd1000; in_src2 = 64'd3; in_valid = 1'b1;
        @(posedge clock); #1 in_valid = 1'b0;
        repeat (10) @(posedge clock);
        #1 flush = 1'b1;
        @(posedge clock); #1 flush = 1'b0;
        chk("flush_ready", {63'b0, in_ready},  64'd1);
        chk("flush_valid", {63'b0, out_valid}, 64'd0);
        vcnt = 0;
        repeat (80) begin
            @(posedge clock); #1;
            if (out_valid) vcnt++;
        end
        chk("flush_never_valid", 64'(vcnt), 64'd0);

        // Flush together with in_valid: not accepted
        in_valid = 1'b1; flush = 1'b1;
        @(posedge clock); #1 in_valid = 1'b0; flush = 1'b0;
        chk("flush_vs_req", {63'b0, in_ready}, 64'd1);

        // Backpressure in DONE
        do_op(OP_DIV, 1'b0, -64'sd20, 64'd3, r, l);
        repeat (5) begin
            @(posedge clock); #1;
            chk("hold_valid",  {63'b0, out_valid}, 64'd1);
            chk("hold_result", out_result, 64'hFFFF_FFFF_FFFF_FFFA);
        end

        // out_ready with a new in_valid in DONE: result taken, request ignored
        in_op = OP_DIV; in_src1 = 64'd9; in_src2 = 64'd0; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clock); #1 out_ready = 1'b0; in_valid = 1'b0;
        chk("done_req_ignored", {63'b0, in_ready},  64'd1);
        chk("done_consumed",    {63'b0, out_valid}, 64'd0);
        repeat (3) @(posedge clock);
        #1 chk("done_no_accept", {63'b0, out_valid}, 64'd0);

        // Reset mid-operation clears the held result
        in_op = OP_DIVU; in_src1 = 64'd100; in_src2 = 64'd7; in_valid = 1'b1;
        @(posedge clock); #1 in_valid = 1'b0;
        repeat (5) @(posedge clock);
        #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        chk("rst_mid_result", out_result, 64'd0);
        chk("rst_mid_ready",  {63'b0, in_ready}, 64'd1);

        run("divu_after", OP_DIVU, 1'b0, 64'd100, 64'd7, 64'd14, 66);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/mdu_div_seq.md
Name: mdu_div_seq

Overview:
- Multi-cycle iterative RV64M divider, the inverse counterpart of the single-cycle combinational multiply path in the EXU.
- Executes DIV/DIVU/REM/REMU and their W variants, one quotient bit per cycle (radix-2 restoring).
- Valid/ready on both ends, so the EXU stalls the pipeline while a divide is in flight.
- Supports a flush from the pipeline's redirect logic.

Parameters:
- XLEN, 64, operand/result width; only 64 is supported.

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high reset
- flush  in  1  kill any in-flight operation
- in_valid  in  1  request valid
- in_ready  out  1  unit can accept a request
- in_op  in  2  operation: 0 DIV, 1 DIVU, 2 REM, 3 REMU
- in_is_w  in  1  32-bit word variant (DIVW etc.)
- in_src1  in  XLEN  dividend
- in_src2  in  XLEN  divisor
- out_valid  out  1  result valid
- out_ready  in  1  consumer takes result
- out_result  out  XLEN  quotient or remainder

Behaviour:
- Interface: one clock (clock); reset is synchronous and active-high (reset).
- Reset values: state IDLE, in_ready=1, out_valid=0, out_result=0, counter=0.
- FSM states:
  - IDLE: in_ready=1. On in_valid & !flush, latch operands/op and go to SPECIAL if a special case is detected, else CALC.
  - CALC: in_ready=0. One iteration per cycle: shift {rem,quo} left 1, trial-subtract |divisor|, set quo LSB on no-borrow. Count is 64 iterations (32 when in_is_w); after the last iteration go to FIX.
  - FIX: apply sign correction, select quotient or remainder, apply W sign-extension, register out_result, go to DONE.
  - SPECIAL: register the special-case result, go to DONE.
  - DONE: out_valid=1. On out_ready go to IDLE. out_result is held stable while waiting.
- No accept in DONE; a new request is taken only in IDLE, i.e. the cycle after the handshake.
- Latency (acceptance edge to out_valid high):
  - 64-bit: 66 cycles (64 CALC + FIX + DONE entry).
  - W: 34 cycles.
  - Special case: 2 cycles.
- Operand prep:
  - W signed: sign-extend the low 32 bits of each source.
  - W unsigned: zero-extend the low 32 bits.
  - Signed ops: take absolute values and iterate unsigned.
- Sign rules:
  - Quotient is negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - For W ops, the low 32 bits of the result are sign-extended to 64, including DIVUW/REMUW.
- Special cases (RISC-V spec, no trap):
  - Divisor==0: quotient = all ones; remainder = dividend (W: sign-extended low 32).
  - Signed overflow (dividend = most negative, divisor = -1): quotient = dividend; remainder = 0. Most negative is 0x8000_0000_0000_0000, or 0x8000_0000 for W.
- Flush:
  - In any state, flush forces IDLE next cycle with out_valid=0.
  - Flush in the same cycle as in_valid: flush wins and the request is not accepted.
  - Flush in DONE while out_ready is high: the result is dropped.
- Reset mid-operation: same as flush; all state and out_result return to reset values.
- Simultaneous out_ready and new in_valid in DONE: the result is consumed and the request is ignored, since in_ready=0. The requester must hold in_valid.

Decomposition:
- Shared package mdu_pkg holds:
  - op encodings DIV_OP_DIV/DIVU/REM/REMU
  - FSM state enum
  - XLEN constant
- One natural sub-module, div_iter_step: the combinational single-iteration shift/subtract datapath, instanced once.
- FSM, counter and sign fix-up live in mdu_div_seq.

Test Plan:
- DIV 64b: src1=-20, src2=3 -> out_result=-6 (0xFFFF_FFFF_FFFF_FFFA); out_valid 66 cycles after accept; REM gives -2.
- DIVU/REMU: src1=0xFFFF_FFFF_FFFF_FFFF, src2=0x10 -> quotient 0x0FFF_FFFF_FFFF_FFFF, remainder 0xF.
- Divide by zero: DIV src1=7, src2=0 -> 0xFFFF_FFFF_FFFF_FFFF after 2 cycles; REM src1=7, src2=0 -> 7.
- Overflow: DIV src1=0x8000_0000_0000_0000, src2=-1 -> 0x8000_0000_0000_0000; REMW src1=0x8000_0000, src2=-1 -> 0.
- W variant: DIVUW src1=0xFFFF_FFFF_8000_0000, src2=1 -> 0xFFFF_FFFF_8000_0000 (sign-extended), latency 34 cycles.
- Flush/backpressure:
  - Flush at CALC iteration 10 -> out_valid never rises, in_ready=1 next cycle.
  - Hold out_ready=0 for 5 cycles in DONE -> out_result stable and out_valid held until the handshake.
